// File: rtl/nonce_sweep_ctrl_if.sv
// Control/datapath bundle for the nonce sweep sequencer.
// master = top-level control plus hash core, slave = the sequencer.
interface nonce_sweep_ctrl_if #(
  parameter int CMP_W = 16
);
  logic             start;
  logic             stop;
  logic [0:31]      nonce_base;
  logic [0:31]      nonce_limit;
  logic [0:CMP_W-1] target;
  logic             hash_valid;
  logic [0:CMP_W-1] hash_prefix;
  logic             hash_start;
  logic [0:31]      nonce_out;
  logic             busy;
  logic             done;
  logic             found_out;
  logic             not_found_out;
  logic             timeout_out;
  logic [0:15]      attempts;

  modport master (
    output start, stop, nonce_base, nonce_limit, target, hash_valid, hash_prefix,
    input  hash_start, nonce_out, busy, done, found_out, not_found_out,
           timeout_out, attempts
  );

  modport slave (
    input  start, stop, nonce_base, nonce_limit, target, hash_valid, hash_prefix,
    output hash_start, nonce_out, busy, done, found_out, not_found_out,
           timeout_out, attempts
  );
endinterface

// File: rtl/nonce_sweep_ctrl.sv
// Nonce search sequencer: walks base..limit, one hash request per candidate,
// watchdog on each result, stops on hit, exhaustion, timeout or abort.
//
// state   | meaning
// IDLE    | waiting for start after reset
// ISSUE   | hash_start high for this one cycle
// WAIT    | waiting for hash_valid, watchdog running
// CHECK   | compare captured prefix, pick next candidate or finish
// DONE    | result flags, nonce and attempts held until next start
module nonce_sweep_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CMP_W   = 16
) (
  input  logic                 clk_a,
  input  logic                 reset,
  nonce_sweep_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  // Watchdog is a down-counter; expiry on the edge where it sits at zero
  // gives exactly TIMEOUT WAIT cycles.
  localparam logic [7:0] WD_LOAD = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wd_q, wd_d;
  logic [0:CMP_W-1] prefix_q, prefix_d;
  logic [0:31]      nonce_q, nonce_d;
  logic [0:15]      attempts_q, attempts_d;
  logic             found_q, found_d;
  logic             not_found_q, not_found_d;
  logic             timeout_q, timeout_d;
  logic             hash_start_q, hash_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    prefix_d    = prefix_q;
    nonce_d     = nonce_q;
    attempts_d  = attempts_q;
    found_d     = found_q;
    not_found_d = not_found_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_ISSUE;
          nonce_d     = bus.nonce_base;
          attempts_d  = '0;
          wd_d        = WD_LOAD;
          found_d     = 1'b0;
          not_found_d = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        state_d = bus.stop ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (bus.stop) begin
          state_d = S_DONE;
        end else if (bus.hash_valid) begin
          prefix_d = bus.hash_prefix;
          state_d  = S_CHECK;
        end else if (wd_q == 8'd0) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_q - 8'd1;
        end
      end
      S_CHECK: begin
        if (bus.stop) begin
          state_d = S_DONE;
        end else begin
          if (attempts_q != 16'hffff) attempts_d = attempts_q + 16'd1;
          if (prefix_q < bus.target) begin
            found_d = 1'b1;
            state_d = S_DONE;
          end else if (nonce_q == bus.nonce_limit) begin
            not_found_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            nonce_d = nonce_q + 32'd1;
            wd_d    = WD_LOAD;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the next state.
    hash_start_d = (state_d == S_ISSUE);
    busy_d       = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk_a) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wd_q         <= '0;
      prefix_q     <= '0;
      nonce_q      <= '0;
      attempts_q   <= '0;
      found_q      <= 1'b0;
      not_found_q  <= 1'b0;
      timeout_q    <= 1'b0;
      hash_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      prefix_q     <= prefix_d;
      nonce_q      <= nonce_d;
      attempts_q   <= attempts_d;
      found_q      <= found_d;
      not_found_q  <= not_found_d;
      timeout_q    <= timeout_d;
      hash_start_q <= hash_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.hash_start    = hash_start_q;
  assign bus.nonce_out     = nonce_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.found_out     = found_q;
  assign bus.not_found_out = not_found_q;
  assign bus.timeout_out   = timeout_q;
  assign bus.attempts      = attempts_q;

endmodule

// File: doc/nonce_sweep_ctrl.md
Name: nonce_sweep_ctrl

Overview:
- Sequencer for the nonce search loop.
- Walks a nonce range from a programmed base to a programmed limit.
- For each candidate, issues a one-cycle start to the external hash core, waits for the result with a watchdog, and compares the hash prefix against the target.
- Stops on success, on range exhaustion, on timeout or on abort. Sits between the top-level control and the hash/nonce datapath.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles without hash_valid before the run is aborted with timeout_out. Legal range is 2..255.
- CMP_W, 16: width of the hash prefix and target compared, with MSB at bit 0.

Ports:
- clk_a  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE and DONE.
- stop  input  1  abort the current run; sampled only while busy.
- nonce_base  input  [0:31]  first nonce of the run.
- nonce_limit  input  [0:31]  last nonce of the run, inclusive.
- target  input  [0:CMP_W-1]  success threshold.
- hash_valid  input  1  hash core result strobe.
- hash_prefix  input  [0:CMP_W-1]  top CMP_W bits of the hash; valid with hash_valid.
- hash_start  output  1  one-cycle request to the hash core.
- nonce_out  output  [0:31]  current candidate nonce; stable from hash_start until CHECK.
- busy  output  1  high in ISSUE, WAIT and CHECK.
- done  output  1  high in DONE.
- found_out  output  1  the run ended with hash_prefix < target.
- not_found_out  output  1  the range was exhausted with no success.
- timeout_out  output  1  the watchdog expired.
- attempts  output  [0:15]  number of candidates checked, saturating at 16'hffff.

Behaviour:
- All outputs are registered.
- Reset value: every output is 0 and the state is IDLE. This applies from any state, mid-run included, and reset overrides start and stop in the same cycle.
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE:
  - start=1 loads nonce_out<=nonce_base, clears attempts, the watchdog and all flags, and goes to ISSUE.
  - hash_start is asserted on that same edge, so it is high exactly one cycle, during ISSUE.
- ISSUE (1 cycle): hash_start=1 and busy=1. Go to WAIT; hash_start falls.
- WAIT:
  - hash_valid=1 captures hash_prefix and goes to CHECK.
  - Otherwise the watchdog increments. When it reaches TIMEOUT, set timeout_out=1 and go to DONE.
  - hash_valid in any state other than WAIT is ignored, including during ISSUE.
- CHECK (1 cycle), evaluated in priority order:
  - attempts increments, saturating.
  - Captured prefix < target (unsigned): found_out=1, go to DONE. nonce_out holds the winning nonce.
  - Else if nonce_out == nonce_limit: not_found_out=1, go to DONE. nonce_out holds the limit.
  - Else nonce_out<=nonce_out+1 (32'hffffffff wraps to 0), clear the watchdog, go to ISSUE, and assert hash_start on the same edge.
- Ranges:
  - base == limit gives exactly one attempt.
  - base > limit sweeps through the wrap to the limit.
- stop:
  - stop=1 in ISSUE, WAIT or CHECK goes to DONE with found, not_found and timeout all 0.
  - stop beats a simultaneous hash_valid and a simultaneous CHECK result.
- DONE:
  - done=1, busy=0. nonce_out, flags and attempts are held.
  - start=1 begins a new run exactly as from IDLE.
  - stop is ignored.
- start while busy is ignored. nonce_base, nonce_limit and target are sampled live and must be held stable during a run.
- Throughput: with hash_valid one cycle after hash_start, each candidate takes 3 cycles (ISSUE, WAIT, CHECK).

Test Plan:
- Immediate hit: base=32'h00000010, limit=32'h000000ff, target=16'h0100, hash_valid one cycle after hash_start with prefix=16'h00ff.
  -> hash_start on cycle 1, DONE on cycle 4, found_out=1, nonce_out=32'h10, attempts=1.
- Hit on the fourth candidate: prefixes 16'hffff, 16'h8000, 16'h0100, 16'h00fe; target=16'h0100; base=32'h20.
  -> 4 hash_start pulses, found_out=1, nonce_out=32'h23, attempts=4. The equal prefix 16'h0100 is not a hit.
- Wrap and exhaust: base=32'hfffffffe, limit=32'h00000001, every prefix 16'hffff.
  -> nonces fe, ff, 0, 1 are issued; not_found_out=1; nonce_out=32'h1; attempts=4.
- Timeout: TIMEOUT=16, hash_valid never asserted.
  -> timeout_out=1 and done=1 exactly 16 WAIT cycles after hash_start falls. A later hash_valid changes nothing.
- Stop and hash_valid in the same WAIT cycle.
  -> DONE with all flags 0. A following start restarts at base with attempts cleared.
- reset pulsed in WAIT mid-run.
  -> the next cycle has every output 0 and the state IDLE. start=1 in the reset cycle is ignored.
